addmul_core: RTL and testbench

- Arithmetic stage directly downstream of the add/multiply pre-stage; consumes its aligned mantissas, unnormalised exponent, sign, direct-result bypass and class flags.
- Add/sub: single-pass two's-complement add of the aligned mantissas.
- Multiply: iterative shift-add over the significand bits.
- Emits an unnormalised wide mantissa plus exponent and sign to the normalise/round stage, using valid/ready handshakes on both sides.

---
 rtl/addmul_if.sv | 41 ++++
 rtl/addmul_core.sv | 165 ++++++++++++++++
 tb/tb_addmul_core.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/addmul_if.sv
// rtl/addmul_if.sv - Operand and result handshake bundle around the add/multiply core
interface addmul_if #(
  parameter int num_bits   = 64,
  parameter int exp_width  = 11,
  parameter int mant_width = 52
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      mul;
  logic                      eff_sub;
  logic [mant_width:0]       big_mant;
  logic [2*mant_width+1:0]   little_mant;
  logic [exp_width+1:0]      unnorm_exp;
  logic                      sign;
  logic                      use_dir_res;
  logic [num_bits-1:0]       direct_result;
  logic [5:0]                in_class;

  logic                      out_valid;
  logic                      out_ready;
  logic [2*mant_width+2:0]   out_mant;
  logic [exp_width+1:0]      out_exp;
  logic                      out_sign;
  logic                      out_use_dir_res;
  logic [num_bits-1:0]       out_direct_result;
  logic [5:0]                out_class;

  modport master (
    output in_valid, mul, eff_sub, big_mant, little_mant, unnorm_exp, sign,
           use_dir_res, direct_result, in_class, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_sign, out_use_dir_res,
           out_direct_result, out_class
  );

  modport slave (
    input  in_valid, mul, eff_sub, big_mant, little_mant, unnorm_exp, sign,
           use_dir_res, direct_result, in_class, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_sign, out_use_dir_res,
           out_direct_result, out_class
  );
endinterface

// File: rtl/addmul_core.sv
// rtl/addmul_core.sv - Add/sub and iterative shift-add multiply ahead of normalise/round
// Optional ADDMUL_RADIX4_EN retires two multiplier bits per MUL cycle.
module addmul_core #(
  parameter int num_bits   = 64,
  parameter int exp_width  = 11,
  parameter int mant_width = 52
) (
  input  logic      clk,
  input  logic      rst_n,
  addmul_if.slave   bus
);
  localparam int SW = mant_width + 1;
  localparam int PW = 2 * mant_width + 2;
  localparam int OW = 2 * mant_width + 3;
`ifdef ADDMUL_RADIX4_EN
  localparam int STEP = 2;
  localparam int LAST = (SW + 1) / 2 - 1;
`else
  localparam int STEP = 1;
  localparam int LAST = mant_width;
`endif
  localparam int CW = $clog2(LAST + 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

  typedef enum logic [1:0] {IDLE, ADD, MUL, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         count;
  logic                  eff_sub_r;
  logic [SW-1:0]         big_r;
  logic [PW-1:0]         little_r;
  logic [PW-1:0]         mcand_r;
  logic [SW-1:0]         mplier_r;
  logic [PW-1:0]         acc_r;
`ifdef ADDMUL_RADIX4_EN
  logic [PW-1:0]         mcand3_r;
`endif

  logic [OW-1:0]         mant_r;
  logic [exp_width+1:0]  exp_r;
  logic                  sign_r;
  logic                  dir_r;
  logic [num_bits-1:0]   word_r;
  logic [5:0]            class_r;

  logic                  in_ready_c, out_valid_c;
  logic [OW:0]           add_a, add_b, add_r, add_neg;
  logic [PW-1:0]         pp, acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid)
          state_nxt = bus.use_dir_res ? DONE : (bus.mul ? MUL : ADD);
      end
      ADD:  state_nxt = DONE;
      MUL:  if (count == LAST_CNT) state_nxt = DONE;
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One spare top bit so a subtraction that goes negative is visible as add_r[OW].
  always_comb begin
    add_a   = {2'b00, big_r, {SW{1'b0}}};
    add_b   = {1'b0, little_r};
    add_r   = eff_sub_r ? (add_a - add_b) : (add_a + add_b);
    add_neg = '0 - add_r;
  end

  always_comb begin
    pp = '0;
`ifdef ADDMUL_RADIX4_EN
    case (mplier_r[1:0])
      2'd1:    pp = mcand_r;
      2'd2:    pp = mcand_r << 1;
      2'd3:    pp = mcand3_r;
      default: pp = '0;
    endcase
`else
    if (mplier_r[0]) pp = mcand_r;
`endif
    acc_nxt = acc_r + pp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      eff_sub_r <= 1'b0;
      big_r     <= '0;
      little_r  <= '0;
      mcand_r   <= '0;
      mplier_r  <= '0;
      acc_r     <= '0;
`ifdef ADDMUL_RADIX4_EN
      mcand3_r  <= '0;
`endif
      mant_r    <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      dir_r     <= 1'b0;
      word_r    <= '0;
      class_r   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          count     <= '0;
          eff_sub_r <= bus.eff_sub;
          big_r     <= bus.big_mant;
          little_r  <= bus.little_mant;
          mcand_r   <= PW'(bus.big_mant);
          mplier_r  <= bus.little_mant[2*mant_width+1:mant_width+1];
          acc_r     <= '0;
`ifdef ADDMUL_RADIX4_EN
          mcand3_r  <= PW'(bus.big_mant) + (PW'(bus.big_mant) << 1);
`endif
          mant_r    <= '0;
          exp_r     <= bus.unnorm_exp;
          sign_r    <= bus.sign;
          dir_r     <= bus.use_dir_res;
          word_r    <= bus.direct_result;
          class_r   <= bus.in_class;
        end
        ADD: begin
          if (add_r[OW]) begin
            mant_r <= add_neg[OW-1:0];
            sign_r <= ~sign_r;
          end else begin
            mant_r <= add_r[OW-1:0];
            if (add_r == '0) sign_r <= 1'b0;
          end
        end
        MUL: begin
          acc_r    <= acc_nxt;
          mcand_r  <= mcand_r << STEP;
          mplier_r <= mplier_r >> STEP;
          count    <= count + 1'b1;
          if (count == LAST_CNT) mant_r <= {1'b0, acc_nxt};
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready          = in_ready_c;
  assign bus.out_valid         = out_valid_c;
  assign bus.out_mant          = mant_r;
  assign bus.out_exp           = exp_r;
  assign bus.out_sign          = sign_r;
  assign bus.out_use_dir_res   = dir_r;
  assign bus.out_direct_result = word_r;
  assign bus.out_class         = class_r;
endmodule

// File: tb/tb_addmul_core.sv
// tb/tb_addmul_core.sv - Table-driven and scoreboarded bench for addmul_core
module tb_addmul_core;
`ifdef ADDMUL_RADIX4_EN
  localparam int MUL_LAT = 28;
`else
  localparam int MUL_LAT = 54;
`endif
  localparam logic [5:0] CLS_NORM = 6'b000100;
  localparam logic [5:0] CLS_QNAN = 6'b000010;

  typedef struct packed {
    logic          mul;
    logic          eff_sub;
    logic [52:0]   big;
    logic [105:0]  little;
    logic [12:0]   exp;
    logic          sign;
    logic          dir;
    logic [63:0]   word;
    logic [5:0]    cls;
    logic [106:0]  e_mant;
    logic          e_sign;
    int            e_lat;
  } vec_t;

  typedef struct packed {
    logic [106:0]  mant;
    logic          sign;
    logic [12:0]   exp;
    logic          dir;
    logic [63:0]   word;
    logic [5:0]    cls;
    int            lat;
  } exp_t;

  logic clk, rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vecs[8];

  addmul_if ifc ();
  addmul_core u_dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [107:0] model(input logic m, input logic es, input logic s,
                                         input logic dir, input logic [52:0] b,
                                         input logic [105:0] l);
    logic [129:0] a, bb;
    logic [127:0] prod;
    if (dir) return {s, 107'd0};
    if (m) begin
      prod = 128'(b) * 128'(l[105:53]);
      return {s, 1'b0, prod[105:0]};
    end
    a  = 130'(b) << 53;
    bb = 130'(l);
    if (!es)    return {s, a[106:0] + bb[106:0]};
    if (a == bb) return {1'b0, 107'd0};
    if (a > bb)  return {s, 107'(a - bb)};
    return {~s, 107'(bb - a)};
  endfunction

  task automatic apply(input vec_t v, input exp_t e);
    int n;
    @(negedge clk);
    n = 0;
    while (!ifc.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) check("in_ready_timeout", 0, 1);
    ifc.mul           = v.mul;
    ifc.eff_sub       = v.eff_sub;
    ifc.big_mant      = v.big;
    ifc.little_mant   = v.little;
    ifc.unnorm_exp    = v.exp;
    ifc.sign          = v.sign;
    ifc.use_dir_res   = v.dir;
    ifc.direct_result = v.word;
    ifc.in_class      = v.cls;
    ifc.in_valid      = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic await_result();
    int   lat;
    exp_t e;
    lat = 1;
    while (!ifc.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ifc.out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("out_mant", ifc.out_mant, e.mant);
    check("out_sign", ifc.out_sign, e.sign);
    check("out_exp", ifc.out_exp, e.exp);
    check("out_use_dir_res", ifc.out_use_dir_res, e.dir);
    check("out_direct_result", ifc.out_direct_result, e.word);
    check("out_class", ifc.out_class, e.cls);
    check("latency", lat, e.lat);
    check("in_ready_busy", ifc.in_ready, 0);
  endtask

  task automatic release_out();
    @(negedge clk);
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    check("valid_dropped", ifc.out_valid, 0);
    check("in_ready_back", ifc.in_ready, 1);
  endtask

  function automatic exp_t exp_of(input vec_t v);
    return '{mant: v.e_mant, sign: v.e_sign, exp: v.exp, dir: v.dir,
             word: v.dir ? v.word : v.word, cls: v.cls, lat: v.e_lat};
  endfunction

  initial begin
    vec_t v;
    exp_t e;
    logic [106:0] snap;
    logic [107:0] m;
    logic [127:0] r128;
    logic [63:0]  r64;
    logic [31:0]  r32;
    bit           stale;

    //        mul sub big            little               exp      s  dir word                    cls       e_mant                                      e_s lat
    vecs[0] = '{1'b0, 1'b0, 53'd1 << 52, 106'd1 << 105, 13'h3ff, 1'b0, 1'b0, 64'd0, CLS_NORM, 107'd1 << 106, 1'b0, 2};
    vecs[1] = '{1'b0, 1'b1, 53'd1 << 52, 106'd1 << 105, 13'h400, 1'b1, 1'b0, 64'd0, CLS_NORM, 107'd0, 1'b0, 2};
    vecs[2] = '{1'b0, 1'b1, 53'd1 << 52, 106'd3 << 104, 13'h3fe, 1'b0, 1'b0, 64'd0, CLS_NORM, 107'd1 << 104, 1'b1, 2};
    vecs[3] = '{1'b1, 1'b0, 53'd3 << 51, 106'd3 << 104, 13'h7fe, 1'b1, 1'b0, 64'd0, CLS_NORM, 107'd9 << 102, 1'b1, MUL_LAT};
    vecs[4] = '{1'b1, 1'b0, 53'd1 << 52, 106'd1 << 105, 13'h123, 1'b0, 1'b1, 64'h7FC0000000000000, CLS_QNAN, 107'd0, 1'b0, 1};
    vecs[5] = '{1'b0, 1'b0, {53{1'b1}}, {106{1'b1}}, 13'h1fff, 1'b1, 1'b0, 64'd0, CLS_NORM,
                (107'd1 << 107) - (107'd1 << 53) - 107'd1, 1'b1, 2};
    vecs[6] = '{1'b1, 1'b0, {53{1'b1}}, {{53{1'b1}}, 53'd0}, 13'h0, 1'b0, 1'b0, 64'd0, CLS_NORM,
                (107'd1 << 106) - (107'd1 << 54) + 107'd1, 1'b0, MUL_LAT};
    vecs[7] = '{1'b1, 1'b0, 53'd1 << 52, 106'd0, 13'h55, 1'b1, 1'b0, 64'd0, CLS_NORM, 107'd0, 1'b1, MUL_LAT};

    ifc.in_valid = 1'b0; ifc.mul = 1'b0; ifc.eff_sub = 1'b0; ifc.big_mant = '0;
    ifc.little_mant = '0; ifc.unnorm_exp = '0; ifc.sign = 1'b0; ifc.use_dir_res = 1'b0;
    ifc.direct_result = '0; ifc.in_class = '0; ifc.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", ifc.in_ready, 1);
    check("reset_out_valid", ifc.out_valid, 0);
    check("reset_out_mant", ifc.out_mant, 0);
    check("reset_out_class", ifc.out_class, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i], exp_of(vecs[i]));
      await_result();
      release_out();
    end

    for (int i = 0; i < 6; i++) begin
      r128 = {$urandom, $urandom, $urandom, $urandom};
      r64  = {$urandom, $urandom};
      r32  = $urandom;
      v.mul     = r32[0];
      v.eff_sub = r32[1];
      v.sign    = r32[2];
      v.dir     = 1'b0;
      v.exp     = r32[28:16];
      v.big     = {1'b1, r64[51:0]};
      v.little  = r128[105:0];
      v.word    = '0;
      v.cls     = CLS_NORM;
      m = model(v.mul, v.eff_sub, v.sign, v.dir, v.big, v.little);
      v.e_mant  = m[106:0];
      v.e_sign  = m[107];
      v.e_lat   = v.mul ? MUL_LAT : 2;
      apply(v, exp_of(v));
      await_result();
      release_out();
    end

    // Backpressure: result must hold while a competing bundle is offered.
    apply(vecs[2], exp_of(vecs[2]));
    await_result();
    snap = ifc.out_mant;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.big_mant = 53'd7;
    ifc.use_dir_res = 1'b0;
    ifc.mul = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", ifc.out_valid, 1);
      check("hold_mant", ifc.out_mant, snap);
      check("hold_in_ready", ifc.in_ready, 0);
    end
    ifc.in_valid = 1'b0;
    release_out();

    // Reset in the middle of a multiply abandons it.
    apply(vecs[3], exp_of(vecs[3]));
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", ifc.out_valid, 0);
    check("midreset_in_ready", ifc.in_ready, 1);
    check("midreset_out_mant", ifc.out_mant, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (ifc.out_valid) stale = 1'b1;
    end
    check("no_stale_result", stale, 0);

    apply(vecs[3], exp_of(vecs[3]));
    await_result();
    release_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
